// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch sequencer
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT, STEP} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int PC_INC = 4;
    localparam int BOOT_CNT_W = 4;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: word-aligned program counter with redirect load and fetch advance
module fetch_pc_reg import fetch_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    output logic [ADDR_W-1:0] o_pc
);
    logic [ADDR_W-1:0] r_pc;

    // redirect wins over advance; the increment wraps naturally at the top of the address space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pc <= RESET_PC;
        else if (i_load) r_pc <= i_load_addr & ~ADDR_W'(3);
        else if (i_en) r_pc <= r_pc + ADDR_W'(PC_INC);
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage controller (boot delay, freeze, branch redirect; debug halt/step with FETCH_DEBUG_EN)
module fetch_sequencer import fetch_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int BOOT_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_freeze,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_addr,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [DATA_W-1:0] i_imem_data,
`ifdef FETCH_DEBUG_EN
    input  logic              i_dbg_halt_req,
    input  logic              i_dbg_step,
    output logic              o_dbg_halted,
`endif
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [DATA_W-1:0] o_if_instr,
    output logic              o_if_valid
);
    fetch_state_t            r_state;
    logic [BOOT_CNT_W-1:0]   r_boot_cnt;
    logic [ADDR_W-1:0]       r_if_pc;
    logic [DATA_W-1:0]       r_if_instr;
    logic                    r_if_valid;
    logic                    r_dbg_halted;
    logic [ADDR_W-1:0]       w_pc;
    logic                    w_run;
    logic                    w_load;
    logic                    w_fetch;

    assign w_run   = (r_state == RUN) || (r_state == STEP);
    assign w_load  = i_branch_taken && (r_state != BOOT);
    assign w_fetch = w_run && !i_branch_taken && !i_freeze;

    fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_en        (w_fetch),
        .i_load_addr (i_branch_addr),
        .o_pc        (w_pc)
    );

    // sequencing FSM plus boot counter and IF/ID register; branch flushes, freeze holds everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_boot_cnt   <= '0;
            r_if_pc      <= '0;
            r_if_instr   <= DATA_W'(NOP_INSTR);
            r_if_valid   <= 1'b0;
            r_dbg_halted <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_boot_cnt <= r_boot_cnt + BOOT_CNT_W'(1);
                    if (r_boot_cnt == BOOT_CNT_W'(BOOT_DELAY - 1)) r_state <= RUN;
                end
                RUN: begin
                    if (i_branch_taken) begin
                        r_if_instr <= DATA_W'(NOP_INSTR);
                        r_if_valid <= 1'b0;
                    end else if (!i_freeze) begin
                        r_if_instr <= i_imem_data;
                        r_if_pc    <= w_pc + ADDR_W'(PC_INC);
                        r_if_valid <= 1'b1;
                    end
`ifdef FETCH_DEBUG_EN
                    if (i_dbg_halt_req && !i_branch_taken) begin
                        r_state      <= HALT;
                        r_dbg_halted <= 1'b1;
                    end
`endif
                end
`ifdef FETCH_DEBUG_EN
                HALT: begin
                    r_if_valid <= 1'b0;
                    if (i_branch_taken) r_if_instr <= DATA_W'(NOP_INSTR);
                    if (i_dbg_step) begin
                        r_state      <= STEP;
                        r_dbg_halted <= 1'b0;
                    end else if (!i_dbg_halt_req) begin
                        r_state      <= RUN;
                        r_dbg_halted <= 1'b0;
                    end
                end
                STEP: begin
                    if (i_branch_taken) begin
                        r_if_instr   <= DATA_W'(NOP_INSTR);
                        r_if_valid   <= 1'b0;
                        r_state      <= HALT;
                        r_dbg_halted <= 1'b1;
                    end else if (!i_freeze) begin
                        r_if_instr   <= i_imem_data;
                        r_if_pc      <= w_pc + ADDR_W'(PC_INC);
                        r_if_valid   <= 1'b1;
                        r_state      <= HALT;
                        r_dbg_halted <= 1'b1;
                    end
                end
`endif
                default: r_state <= BOOT;
            endcase
        end
    end

    assign o_imem_addr = {w_pc[ADDR_W-1:2], 2'b00};
    assign o_if_pc     = r_if_pc;
    assign o_if_instr  = r_if_instr;
    assign o_if_valid  = r_if_valid;
`ifdef FETCH_DEBUG_EN
    assign o_dbg_halted = r_dbg_halted;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer (debug section under FETCH_DEBUG_EN)
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    int          n_pass = 0;
    int          n_total = 0;
`ifdef FETCH_DEBUG_EN
    logic        dbg_halt_req = 1'b0;
    logic        dbg_step = 1'b0;
    logic        dbg_halted;
`endif

    always #5 clk = ~clk;

    assign imem_data = {16'hC0DE, imem_addr[15:0]};

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_freeze       (freeze),
        .i_branch_taken (branch_taken),
        .i_branch_addr  (branch_addr),
        .o_imem_addr    (imem_addr),
        .i_imem_data    (imem_data),
`ifdef FETCH_DEBUG_EN
        .i_dbg_halt_req (dbg_halt_req),
        .i_dbg_step     (dbg_step),
        .o_dbg_halted   (dbg_halted),
`endif
        .o_if_pc        (if_pc),
        .o_if_instr     (if_instr),
        .o_if_valid     (if_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_instr"}, if_instr, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
`ifdef FETCH_DEBUG_EN
        chk({tag, "_halted"}, {31'b0, dbg_halted}, 32'h0);
`endif
    endtask

    task automatic boot_sequence(input string tag);
        tick();
        chk({tag, "_e1_valid"}, {31'b0, if_valid}, 32'h0);
        tick();
        chk({tag, "_e2_valid"}, {31'b0, if_valid}, 32'h0);
        tick();
        chk({tag, "_e3_valid"}, {31'b0, if_valid}, 32'h1);
        chk({tag, "_e3_instr"}, if_instr, 32'hC0DE0000);
        chk({tag, "_e3_pc"}, if_pc, 32'h4);
    endtask

    initial begin
        #1;
        check_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;
        boot_sequence("boot");

        tick();
        chk("run_pc8", if_pc, 32'h8);
        chk("run_valid", {31'b0, if_valid}, 32'h1);
        chk("run_addr8", imem_addr, 32'h8);

        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_if_pc", if_pc, 32'h8);
            chk("frz_addr", imem_addr, 32'h8);
            chk("frz_valid", {31'b0, if_valid}, 32'h1);
        end
        freeze = 1'b0;
        tick();
        chk("unfrz_pc", if_pc, 32'hC);
        chk("unfrz_instr", if_instr, 32'hC0DE0008);
        tick();
        chk("run_pc16", if_pc, 32'h10);
        tick();
        chk("run_pc20", if_pc, 32'h14);

        branch_taken = 1'b1;
        freeze = 1'b1;
        branch_addr = 32'h93;
        tick();
        chk("br_valid", {31'b0, if_valid}, 32'h0);
        chk("br_instr", if_instr, 32'h0);
        chk("br_addr", imem_addr, 32'h90);
        branch_taken = 1'b0;
        freeze = 1'b0;
        tick();
        chk("br_tgt_instr", if_instr, 32'hC0DE0090);
        chk("br_tgt_pc", if_pc, 32'h94);
        chk("br_tgt_valid", {31'b0, if_valid}, 32'h1);

`ifdef FETCH_DEBUG_EN
        branch_taken = 1'b1;
        branch_addr = 32'hC;
        tick();
        branch_taken = 1'b0;
        chk("dbg_br_addr", imem_addr, 32'hC);
        dbg_halt_req = 1'b1;
        tick();
        chk("halt_entry", {31'b0, dbg_halted}, 32'h1);
        chk("halt_last_pc", if_pc, 32'h10);
        chk("halt_last_valid", {31'b0, if_valid}, 32'h1);
        chk("halt_addr", imem_addr, 32'h10);
        tick();
        chk("halt_bubble", {31'b0, if_valid}, 32'h0);
        chk("halt_hold", imem_addr, 32'h10);
        for (int k = 0; k < 3; k++) begin
            dbg_step = 1'b1;
            tick();
            dbg_step = 1'b0;
            chk("step_enter_valid", {31'b0, if_valid}, 32'h0);
            tick();
            chk("step_valid", {31'b0, if_valid}, 32'h1);
            chk("step_pc", if_pc, 32'h14 + 32'(4 * k));
            chk("step_instr", if_instr, 32'hC0DE0010 + 32'(4 * k));
            tick();
            chk("step_rehalt", {31'b0, dbg_halted}, 32'h1);
            chk("step_bubble", {31'b0, if_valid}, 32'h0);
        end
        dbg_halt_req = 1'b0;
        tick();
        chk("resume_halted", {31'b0, dbg_halted}, 32'h0);
        chk("resume_addr", imem_addr, 32'h1C);
        tick();
        chk("resume_pc", if_pc, 32'h20);
        chk("resume_instr", if_instr, 32'hC0DE001C);
`endif

        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_if_pc", if_pc, 32'h0);
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_instr", if_instr, 32'hC0DE_FFFC);
        tick();
        chk("post_wrap_pc", if_pc, 32'h4);

        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        tick();
        check_reset("rst_hold");
        rst_n = 1'b1;
        boot_sequence("reboot");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
